// File: rtl/fifo_umbrales.sv
// rtl/fifo_umbrales.sv - circular-buffer FIFO with almost-full/almost-empty thresholds
// Flags decode the registered count; fifo_error is sticky until reset.
module fifo_umbrales #(
    parameter int DATA_W    = 10,
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 3,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 2
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              fifo_error,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THRESH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              error_q, error_d;
    logic              wr_ok, rd_ok;

    assign fifo_empty   = (count_q == '0);
    assign fifo_full    = (count_q == DEPTH_C);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign data_out     = data_out_q;
    assign fifo_error   = error_q;
    assign count        = count_q;

    // A pop frees the head slot, so a full FIFO still takes a simultaneous push.
    always_comb begin
        wr_ok      = push & (~fifo_full | pop);
        rd_ok      = pop & ~fifo_empty;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        error_d    = error_q | (push & ~wr_ok) | (pop & fifo_empty);
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (rd_ok) begin
            rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
            data_out_d = mem_q[rd_ptr_q];
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            error_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            error_q    <= error_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule
